// File: rtl/bcd_pkg.sv
// Shared definitions for the serial BCD adder.
// Contents: digit width, largest legal BCD digit, the controller state
// encoding and a helper that flags an illegal (non-BCD) digit.
package bcd_pkg;

  localparam int DIGIT_W = 4;
  localparam int BCD_MAX = 9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // True when a nibble does not encode a decimal digit.
  function automatic logic digit_bad(input logic [DIGIT_W-1:0] d);
    return (d > DIGIT_W'(BCD_MAX));
  endfunction

endpackage

// File: rtl/bcd_adder.sv
// Single-digit BCD adder (purely combinational).
// Ports:
//   a, b  - input BCD digits
//   cin   - carry in
//   s     - corrected BCD sum digit
//   cout  - decimal carry out
//   err   - either input digit is not a legal BCD digit
module bcd_adder
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] a,
  input  logic [DIGIT_W-1:0] b,
  input  logic               cin,
  output logic [DIGIT_W-1:0] s,
  output logic               cout,
  output logic               err
);

  logic [DIGIT_W:0] raw_s;
  logic [DIGIT_W:0] adj_s;

  // Binary add, then add 6 whenever the binary result leaves the decimal range.
  // Illegal digits go through the same rule; only the low nibble is kept.
  always_comb begin
    raw_s = {1'b0, a} + {1'b0, b} + {{DIGIT_W{1'b0}}, cin};
    adj_s = raw_s;
    cout  = 1'b0;
    if (raw_s > (DIGIT_W+1)'(BCD_MAX)) begin
      adj_s = raw_s + (DIGIT_W+1)'(6);
      cout  = 1'b1;
    end else begin
      adj_s = raw_s;
      cout  = 1'b0;
    end
    s   = adj_s[DIGIT_W-1:0];
    err = digit_bad(a) | digit_bad(b);
  end

endmodule

// File: rtl/bcd_serial_add_ctrl.sv
// Serial multi-digit BCD adder: one shared digit adder is stepped over the
// operands least-significant digit first, one digit per clock.
// Ports:
//   clk, rst            - clock, asynchronous active-high reset
//   in_valid/in_ready   - operand handshake (a, b, cin)
//   a, b                - NDIGITS-digit BCD operands, digit 0 in bits [3:0]
//   cin                 - carry into digit 0
//   out_valid/out_ready - result handshake (sum, cout, err)
//   sum, cout           - BCD sum and carry out of the top digit
//   err                 - some operand digit was greater than 9
module bcd_serial_add_ctrl
  import bcd_pkg::*;
#(
  parameter int NDIGITS = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DIGIT_W*NDIGITS-1:0] a,
  input  logic [DIGIT_W*NDIGITS-1:0] b,
  input  logic                       cin,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DIGIT_W*NDIGITS-1:0] sum,
  output logic                       cout,
  output logic                       err
);

  localparam int IDX_W = $clog2(NDIGITS + 1);

  state_t                            state_r;
  state_t                            state_nxt_s;
  logic [NDIGITS-1:0][DIGIT_W-1:0]   a_r;
  logic [NDIGITS-1:0][DIGIT_W-1:0]   b_r;
  logic [NDIGITS-1:0][DIGIT_W-1:0]   sum_r;
  logic [IDX_W-1:0]                  idx_r;
  logic                              carry_r;
  logic                              cout_r;
  logic                              err_r;

  logic [DIGIT_W-1:0]                dig_a_s;
  logic [DIGIT_W-1:0]                dig_b_s;
  logic [DIGIT_W-1:0]                add_sum_s;
  logic                              add_cout_s;
  logic                              add_err_s;
  logic                              accept_s;
  logic                              last_s;

  assign in_ready  = (state_r == ST_IDLE);
  assign out_valid = (state_r == ST_DONE);
  assign sum       = sum_r;
  assign cout      = cout_r;
  assign err       = err_r;

  assign accept_s  = in_valid & in_ready;
  assign last_s    = (idx_r == IDX_W'(NDIGITS - 1));

  // Select the current digit of each latched operand (OR of one-hot terms).
  always_comb begin
    dig_a_s = '0;
    dig_b_s = '0;
    for (int i = 0; i < NDIGITS; i++) begin
      dig_a_s = dig_a_s | ((idx_r == IDX_W'(i)) ? a_r[i] : {DIGIT_W{1'b0}});
      dig_b_s = dig_b_s | ((idx_r == IDX_W'(i)) ? b_r[i] : {DIGIT_W{1'b0}});
    end
  end

  bcd_adder u_bcd_adder (
    .a    (dig_a_s),
    .b    (dig_b_s),
    .cin  (carry_r),
    .s    (add_sum_s),
    .cout (add_cout_s),
    .err  (add_err_s)
  );

  // Next-state decode for the IDLE -> ADD -> DONE sequence.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) state_nxt_s = ST_ADD;
        else          state_nxt_s = ST_IDLE;
      end
      ST_ADD: begin
        if (last_s) state_nxt_s = ST_DONE;
        else        state_nxt_s = ST_ADD;
      end
      ST_DONE: begin
        if (out_ready) state_nxt_s = ST_IDLE;
        else           state_nxt_s = ST_DONE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_nxt_s;
  end

  // Operand capture, per-digit accumulation and result registers.
  // Results are only written in ADD, so they stay frozen throughout DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r     <= '0;
      b_r     <= '0;
      sum_r   <= '0;
      idx_r   <= '0;
      carry_r <= 1'b0;
      cout_r  <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            a_r     <= a;
            b_r     <= b;
            carry_r <= cin;
            idx_r   <= '0;
            cout_r  <= 1'b0;
            err_r   <= 1'b0;
          end
        end
        ST_ADD: begin
          for (int i = 0; i < NDIGITS; i++) begin
            if (idx_r == IDX_W'(i)) sum_r[i] <= add_sum_s;
          end
          carry_r <= add_cout_s;
          err_r   <= err_r | add_err_s;
          idx_r   <= idx_r + IDX_W'(1);
          if (last_s) cout_r <= add_cout_s;
        end
        ST_DONE: begin
          cout_r <= cout_r;
        end
        default: begin
          idx_r <= '0;
        end
      endcase
    end
  end

endmodule
